window_gen_kxk: RTL
===================

Name: window_gen_kxk

Overview:
- Parametrised sliding-window generator for the streaming edge-detection pipeline, sitting between the pixel source and the convolution stages (Gaussian, Sobel, NMS).
- Buffers K-1 image lines plus a KxK register window.
- Accepts pixels under a valid qualifier, resynchronises on start-of-frame and tracks row/column against a fixed frame size.
- Emits either interior-only windows or every window with zero-padded borders, tagged with coordinates and an end-of-frame marker.

Parameters:
- DATA_W, 8, pixel width in bits.
- IMG_W, 256, pixels per line (>= K).
- IMG_H, 256, lines per frame (>= K).
- K, 3, window size; odd, 3..7.
- BORDER, 0, 0 = emit interior windows only; 1 = emit one window per input pixel with out-of-frame taps forced to 0.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- pix_in  in  DATA_W  input pixel, raster order.
- pix_valid  in  1  pix_in is accepted this cycle.
- sof  in  1  first pixel of a frame; meaningful only with pix_valid.
- win_out  out  K*K*DATA_W  window; tap (r,c) at bits [(r*K+c)*DATA_W +: DATA_W].
- win_valid  out  1  win_out, win_row and win_col are valid this cycle.
- win_row  out  clog2(IMG_H)  frame row y of the bottom-right tap.
- win_col  out  clog2(IMG_W)  frame column x of the bottom-right tap.
- eof_out  out  1  qualifies the window of the last frame pixel (IMG_H-1, IMG_W-1).

Behaviour:
- Single clock domain. Reset is asynchronous and active-high on rst.
- Reset values:
  - win_valid=0, eof_out=0, win_out=0, win_row=0, win_col=0.
  - Position counters (y,x)=(0,0).
  - Line memory contents are not reset; correctness never depends on them.
- Accepted pixel:
  - A pixel is accepted when pix_valid=1.
  - When pix_valid=0, all state holds and win_valid=0 on the next cycle (bubbles pass straight through).
- Position tracking:
  - The accepted pixel's position is (y,x), except when sof=1: the position is forced to (0,0) and the counters continue from there.
  - After each accept, x increments. At x=IMG_W-1, x wraps to 0 and y increments.
  - At (IMG_H-1, IMG_W-1), both counters wrap to 0.
- Window definition: tap (r,c) = pixel at (y-(K-1-r), x-(K-1-c)). Tap (K-1,K-1) is the current pixel and tap (0,0) is the oldest.
- Storage:
  - K-1 line memories of IMG_W x DATA_W, indexed by x.
  - On accept, line j is written with line j-1's value at x, and line 0 with pix_in (read-before-write, same cycle).
  - Each window row is a K-deep column shift register fed from the current pixel or the line read.
- Latency:
  - The window and tags for a pixel accepted in cycle n appear registered in cycle n+1 with win_valid=1.
  - This holds if BORDER=1, or if y>=K-1 and x>=K-1.
  - Otherwise win_valid=0 for that pixel.
- BORDER=1 masking:
  - A tap is output as 0 if its row is < 0, or its column is < 0.
  - Row < 0 means y-(K-1-r) < 0, covering rows from before the frame or sof.
  - Column < 0 means x-(K-1-c) < 0, covering stale data shifted in from the previous line.
  - Masking is computed from (y,x) at accept time.
- BORDER=0: masking logic is absent. Only fully in-frame windows are emitted, i.e. (IMG_H-K+1)*(IMG_W-K+1) per frame.
- eof_out:
  - eof_out=1 alongside the window for (IMG_H-1, IMG_W-1).
  - In BORDER=0 that window is always valid.
- sof mid-frame:
  - Immediate resync to (0,0).
  - Lines from the aborted frame are treated as out-of-frame: masked in BORDER=1, not emitted in BORDER=0 until y>=K-1.
- Back-to-back frames: a sof=1 pixel directly after the eof pixel is legal with no gap. A next frame without sof also starts at (0,0) through the wrap.
- Reset mid-frame: outputs clear asynchronously. The next accepted pixel is (0,0) whether or not sof is asserted.
- Width rules:
  - Pixels pass through unmodified; no arithmetic on data.
  - Counters are sized clog2(IMG_W) and clog2(IMG_H). Comparisons use the unsigned counter value.

Test Plan:
- K=3, BORDER=0, IMG_W=8, IMG_H=6, pixel=16*y+x, pix_valid=1 continuous, sof on the first pixel -> exactly 24 windows. The first appears 1 cycle after pixel (2,2) with taps row0={0x00,0x01,0x02}, row1={0x10,0x11,0x12}, row2={0x20,0x21,0x22}, win_row=2, win_col=2. eof_out only on (5,7).
- Same frame with BORDER=1 -> 48 windows:
  - (0,0) window is all zeros except tap(2,2)=0x00.
  - (1,0) window: taps(1,2)=0x00 and (2,2)=0x10, all others zero.
  - Window at (2,1) has column-0 taps all zero.
- Same frame with pix_valid toggling 1,0,0,1 pseudo-randomly -> window contents and coordinates identical to the continuous run; win_valid never asserted in the cycle after a pix_valid=0 cycle.
- Resync: sof at pixel 20 of frame 1 (mid row 2), then a full frame -> frame-2 windows match the clean run. In BORDER=1, no tap carries a frame-1 value.
- K=5, BORDER=0, IMG_W=8, IMG_H=6 -> 8 windows. First at (4,4): tap(0,0)=0x00 and tap(4,4)=0x44.
- rst asserted for one cycle mid-row 3, then a frame without sof -> win_valid=0 immediately. The next accepted pixel is (0,0). The first BORDER=0 window appears at (2,2) of the new frame.

Source files
------------

// File: rtl/window_gen_kxk.sv
// window_gen_kxk
//   Sliding KxK window generator for the streaming edge-detection pipeline.
//   K-1 line memories hold the previous image lines; a KxK register array
//   shifts one column per accepted pixel. Emits interior windows only
//   (BORDER=0) or one window per pixel with out-of-frame taps zeroed
//   (BORDER=1). Each window is tagged with the frame position of its
//   bottom-right tap and an end-of-frame marker.
//
// Ports
//   clk        clock
//   rst        asynchronous, active-high reset
//   pix_in     input pixel, raster order
//   pix_valid  pixel accepted this cycle
//   sof        first pixel of a frame (only meaningful with pix_valid)
//   win_out    window; tap (r,c) at [(r*K+c)*DATA_W +: DATA_W]
//   win_valid  win_out / win_row / win_col valid this cycle
//   win_row    frame row of the bottom-right tap
//   win_col    frame column of the bottom-right tap
//   eof_out    window belongs to the last pixel of the frame
module window_gen_kxk #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int K      = 3,
  parameter int BORDER = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          pix_in,
  input  logic                       pix_valid,
  input  logic                       sof,
  output logic [K*K*DATA_W-1:0]      win_out,
  output logic                       win_valid,
  output logic [$clog2(IMG_H)-1:0]   win_row,
  output logic [$clog2(IMG_W)-1:0]   win_col,
  output logic                       eof_out
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_FIRST = XW'(K - 1);
  localparam logic [YW-1:0] Y_FIRST = YW'(K - 1);

  logic [XW-1:0] x_q, x_d, px;
  logic [YW-1:0] y_q, y_d, py;

  // line_mem[j] holds image row y-1-j at each column
  logic [DATA_W-1:0] line_mem [K-1][IMG_W];
  logic [DATA_W-1:0] line_rd  [K-1];
  logic [DATA_W-1:0] col_in   [K];

  // Packed [row][col][bit] flattens to exactly the win_out tap layout
  logic [K-1:0][K-1:0][DATA_W-1:0] sr_q, sr_d;
  logic [K-1:0][K-1:0][DATA_W-1:0] win_q, win_d;

  logic          valid_q, valid_d;
  logic          eof_q, eof_d;
  logic [YW-1:0] row_q, row_d;
  logic [XW-1:0] col_q, col_d;
  logic          emit;

  // Position of the pixel presented this cycle; sof forces (0,0)
  always_comb begin
    px  = sof ? '0 : x_q;
    py  = sof ? '0 : y_q;
    x_d = x_q;
    y_d = y_q;
    if (pix_valid) begin
      if (px == X_LAST) begin
        x_d = '0;
        y_d = (py == Y_LAST) ? '0 : py + 1'b1;
      end else begin
        x_d = px + 1'b1;
        y_d = py;
      end
    end
  end

  always_comb begin
    for (int j = 0; j < K-1; j++) begin
      line_rd[j] = line_mem[j][px];
    end
    // Window row r sees image row y-(K-1-r): bottom row is the live pixel
    col_in[K-1] = pix_in;
    for (int r = 0; r < K-1; r++) begin
      col_in[r] = line_rd[K-2-r];
    end
  end

  always_comb begin
    sr_d = sr_q;
    if (pix_valid) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K-1; c++) begin
          sr_d[r][c] = sr_q[r][c+1];
        end
        sr_d[r][K-1] = col_in[r];
      end
    end
  end

  // Taps above the frame (rows before sof) or left of column 0 (stale data
  // from the previous line) are zeroed; this folds away when BORDER=0.
  always_comb begin
    win_d = sr_d;
    if (BORDER != 0) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          if ((py < YW'(K-1-r)) || (px < XW'(K-1-c))) begin
            win_d[r][c] = '0;
          end
        end
      end
    end
  end

  always_comb begin
    emit    = (BORDER != 0) || ((py >= Y_FIRST) && (px >= X_FIRST));
    valid_d = pix_valid && emit;
    eof_d   = pix_valid && emit && (py == Y_LAST) && (px == X_LAST);
    row_d   = pix_valid ? py : row_q;
    col_d   = pix_valid ? px : col_q;
  end

  always_ff @(posedge clk) begin
    if (pix_valid) begin
      line_mem[0][px] <= pix_in;
      for (int j = 1; j < K-1; j++) begin
        line_mem[j][px] <= line_rd[j-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q     <= '0;
      y_q     <= '0;
      sr_q    <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      eof_q   <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      sr_q    <= sr_d;
      if (pix_valid) begin
        win_q <= win_d;
      end
      valid_q <= valid_d;
      eof_q   <= eof_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  assign win_out   = win_q;
  assign win_valid = valid_q;
  assign win_row   = row_q;
  assign win_col   = col_q;
  assign eof_out   = eof_q;

endmodule
